// File: rtl/led_bus_master.sv
// Register-bus initiator for the LED controller: queues read/write commands in a
// small FIFO and runs each one as a SETUP then STROBE bus cycle.
module led_bus_master #(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_400K,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rw,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [DATA_BITS-1:0] bus_wdata,
  output logic                 bus_data_oe,
  input  logic [DATA_BITS-1:0] bus_rdata,
  output logic                 bus_w_en,
  output logic                 bus_r_en
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  state_t           r_state, w_next;
  logic             r_rw;
  logic             w_push, w_pop, w_empty, w_full;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign cmd_ready = reset_n && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign busy      = !w_empty || (r_state != IDLE);

  // Storage is left unreset; only the pointers and count define occupancy.
  always_ff @(posedge clk_400K) begin
    if (w_push) r_mem[r_wr_ptr] <= '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge clk_400K) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_400K) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rw      <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      r_state   <= w_next;
      rsp_valid <= (r_state == STROBE) && r_rw;
      if (w_pop) begin
        r_rw      <= r_mem[r_rd_ptr].rw;
        bus_addr  <= r_mem[r_rd_ptr].addr;
        bus_wdata <= r_mem[r_rd_ptr].wdata;
      end
      if ((r_state == STROBE) && r_rw) rsp_data <= bus_rdata;
    end
  end

  // Data is driven only for writes, so oe and r_en can never overlap.
  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    bus_data_oe = 1'b0;
    bus_w_en    = 1'b0;
    bus_r_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = SETUP;
        end
      end
      SETUP: begin
        bus_data_oe = !r_rw;
        w_next      = STROBE;
      end
      STROBE: begin
        bus_data_oe = !r_rw;
        bus_w_en    = !r_rw;
        bus_r_en    = r_rw;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
